sram_arbiter: RTL

- Shares the single 32-bit-wide external SRAM (18-bit word address) between the CPU data/instruction port and the video refresh fetcher.
- Sequences the asynchronous SRAM control strobes (ce_n, oe_n, we_n, be_n) with a parameterised number of wait states.
- Video refresh has absolute priority so the 1024x768 scan never starves.
- Sits between the CPU memory interface, the video controller and the SRAM pad drivers, in the CPU clock domain.

---
 rtl/sram_arbiter_if.sv | 42 ++++
 rtl/sram_arbiter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter_if.sv
// Signal bundle between sram_arbiter, its CPU and video clients and the SRAM pads.
// The arbiter uses the slave view; the environment (CPU, video, pads) uses the master view.
interface sram_arbiter_if #(
    parameter int unsigned AW = 18
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_adr;
    logic [31:0]   cpu_wdata;
    logic [3:0]    cpu_be;
    logic          cpu_ack;
    logic [31:0]   cpu_rdata;

    logic          vid_req;
    logic [AW-1:0] vid_adr;
    logic [31:0]   vid_data;
    logic          vid_valid;
    logic          vid_ovr;

    logic [AW-1:0] sram_adr;
    logic [31:0]   sram_dout;
    logic [31:0]   sram_din;
    logic          sram_doe;
    logic          sram_ce_n;
    logic          sram_oe_n;
    logic          sram_we_n;
    logic [3:0]    sram_be_n;

    modport slave (
        input  cpu_req, cpu_we, cpu_adr, cpu_wdata, cpu_be,
        input  vid_req, vid_adr, sram_din,
        output cpu_ack, cpu_rdata, vid_data, vid_valid, vid_ovr,
        output sram_adr, sram_dout, sram_doe, sram_ce_n, sram_oe_n, sram_we_n, sram_be_n
    );

    modport master (
        output cpu_req, cpu_we, cpu_adr, cpu_wdata, cpu_be,
        output vid_req, vid_adr, sram_din,
        input  cpu_ack, cpu_rdata, vid_data, vid_valid, vid_ovr,
        input  sram_adr, sram_dout, sram_doe, sram_ce_n, sram_oe_n, sram_we_n, sram_be_n
    );
endinterface

// File: rtl/sram_arbiter.sv
// Shares one asynchronous 32-bit SRAM between the CPU port and the video refresh fetcher.
// Video has absolute priority, but a CPU access that has started always runs to completion.
module sram_arbiter #(
    parameter int unsigned WS = 1,
    parameter int unsigned AW = 18
) (
    input  logic           clk,
    input  logic           rst,
    sram_arbiter_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_VRD, S_CRD, S_CWS, S_CWP, S_CWH, S_DONE
    } state_e;

    localparam logic [2:0] WS_LD = 3'(WS);

    state_e        state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic          vid_pend_q, vid_pend_d;
    logic [AW-1:0] vid_adr_q, vid_adr_d;
    logic          vid_ovr_q, vid_ovr_d;
    logic          cpu_ack_q, cpu_ack_d;
    logic          vid_valid_q, vid_valid_d;
    logic [31:0]   cpu_rdata_q, cpu_rdata_d;
    logic [31:0]   vid_data_q, vid_data_d;
    logic [AW-1:0] sram_adr_q, sram_adr_d;
    logic [31:0]   sram_dout_q, sram_dout_d;
    logic          sram_doe_q, sram_doe_d;
    logic          sram_ce_n_q, sram_ce_n_d;
    logic          sram_oe_n_q, sram_oe_n_d;
    logic          sram_we_n_q, sram_we_n_d;
    logic [3:0]    sram_be_n_q, sram_be_n_d;
    logic          vid_want;

    // A pulse arriving this cycle counts as pending, so IDLE and DONE react without a bubble.
    assign vid_want = vid_pend_q | bus.vid_req;

    always_comb begin
        // NOTE: every _d takes its default first, so no branch can infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        vid_adr_d   = bus.vid_req ? bus.vid_adr : vid_adr_q;
        vid_pend_d  = vid_want;
        vid_ovr_d   = vid_ovr_q | (bus.vid_req & vid_pend_q);
        cpu_ack_d   = 1'b0;
        vid_valid_d = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        vid_data_d  = vid_data_q;
        sram_adr_d  = sram_adr_q;
        sram_dout_d = sram_dout_q;

        case (state_q)
            S_IDLE: begin
                if (vid_want) begin
                    state_d = S_VRD;
                end else if (bus.cpu_req && !cpu_ack_q) begin
                    state_d = bus.cpu_we ? S_CWS : S_CRD;
                end
            end
            S_VRD: begin
                if (cnt_q == 3'd0) begin
                    state_d     = S_DONE;
                    vid_data_d  = bus.sram_din;
                    vid_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_CRD: begin
                if (cnt_q == 3'd0) begin
                    state_d     = S_DONE;
                    cpu_rdata_d = bus.sram_din;
                    cpu_ack_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_CWS: state_d = S_CWP;
            S_CWP: begin
                if (cnt_q == 3'd0) state_d = S_CWH;
                else               cnt_d   = cnt_q - 3'd1;
            end
            S_CWH: begin
                state_d   = S_DONE;
                cpu_ack_d = 1'b1;
            end
            // CPU is never started from here: its req is still high during the ack cycle.
            S_DONE:  state_d = vid_want ? S_VRD : S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (state_d != state_q) begin
            case (state_d)
                S_VRD: begin
                    cnt_d      = WS_LD;
                    vid_pend_d = 1'b0;
                    sram_adr_d = vid_adr_d;
                end
                S_CRD: begin
                    cnt_d      = WS_LD;
                    sram_adr_d = bus.cpu_adr;
                end
                S_CWS: begin
                    sram_adr_d  = bus.cpu_adr;
                    sram_dout_d = bus.cpu_wdata;
                end
                S_CWP:   cnt_d = WS_LD;
                default: ;
            endcase
        end

        // Strobes are decoded from the next state so the pads see clean flop outputs.
        sram_ce_n_d = !(state_d inside {S_VRD, S_CRD, S_CWS, S_CWP, S_CWH});
        sram_oe_n_d = !(state_d inside {S_VRD, S_CRD});
        sram_we_n_d = (state_d != S_CWP);
        sram_doe_d  = state_d inside {S_CWS, S_CWP, S_CWH};
        case (state_d)
            S_VRD, S_CRD: sram_be_n_d = 4'h0;
            S_CWS:        sram_be_n_d = ~bus.cpu_be;
            S_CWP, S_CWH: sram_be_n_d = sram_be_n_q;
            default:      sram_be_n_d = 4'hF;
        endcase
    end

    // NOTE: state registers use non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 3'd0;
            vid_pend_q  <= 1'b0;
            vid_adr_q   <= '0;
            vid_ovr_q   <= 1'b0;
            cpu_ack_q   <= 1'b0;
            vid_valid_q <= 1'b0;
            cpu_rdata_q <= 32'd0;
            vid_data_q  <= 32'd0;
            sram_adr_q  <= '0;
            sram_dout_q <= 32'd0;
            sram_doe_q  <= 1'b0;
            sram_ce_n_q <= 1'b1;
            sram_oe_n_q <= 1'b1;
            sram_we_n_q <= 1'b1;
            sram_be_n_q <= 4'hF;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            vid_pend_q  <= vid_pend_d;
            vid_adr_q   <= vid_adr_d;
            vid_ovr_q   <= vid_ovr_d;
            cpu_ack_q   <= cpu_ack_d;
            vid_valid_q <= vid_valid_d;
            cpu_rdata_q <= cpu_rdata_d;
            vid_data_q  <= vid_data_d;
            sram_adr_q  <= sram_adr_d;
            sram_dout_q <= sram_dout_d;
            sram_doe_q  <= sram_doe_d;
            sram_ce_n_q <= sram_ce_n_d;
            sram_oe_n_q <= sram_oe_n_d;
            sram_we_n_q <= sram_we_n_d;
            sram_be_n_q <= sram_be_n_d;
        end
    end

    assign bus.cpu_ack   = cpu_ack_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.vid_valid = vid_valid_q;
    assign bus.vid_data  = vid_data_q;
    assign bus.vid_ovr   = vid_ovr_q;
    assign bus.sram_adr  = sram_adr_q;
    assign bus.sram_dout = sram_dout_q;
    assign bus.sram_doe  = sram_doe_q;
    assign bus.sram_ce_n = sram_ce_n_q;
    assign bus.sram_oe_n = sram_oe_n_q;
    assign bus.sram_we_n = sram_we_n_q;
    assign bus.sram_be_n = sram_be_n_q;
endmodule
